// File: rtl/rd_adder_pipe_pkg.sv
// Kill/propagate/generate encoding shared by the recursive-doubling adder.
package kpg_pkg;

    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_KILL = 2'b00;
    localparam kpg_t KPG_PROP = 2'b01;
    localparam kpg_t KPG_GEN  = 2'b11;

    // 2'b10 never leaves the input rank but is still a propagate code.
    function automatic logic is_prop(kpg_t k);
        return k[1] ^ k[0];
    endfunction

endpackage

// File: rtl/rd_adder_pipe_if.sv
// Operand/result handshake bundle for rd_adder_pipe.
interface rd_adder_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output flush, in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  flush, in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/rd_adder_pipe_kpg_cell.sv
// 2:1 KPG combine: a propagating upper span takes the lower span's status.
module kpg_cell
    import kpg_pkg::*;
(
    input  kpg_t hi_i,
    input  kpg_t lo_i,
    output kpg_t out_o
);
    assign out_o = is_prop(hi_i) ? lo_i : hi_i;
endmodule

// File: rtl/rd_adder_pipe.sv
// Pipelined recursive-doubling adder/subtractor: input KPG rank, one rank
// per doubling level, then a registered result rank.
module rd_adder_pipe
    import kpg_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned LOG2W = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst,
    rd_adder_pipe_if.slave bus
);

    logic                   vld_q [0:LOG2W];
    kpg_t [WIDTH:0]         kpg_q [0:LOG2W];
    logic [WIDTH-1:0]       hs_q  [0:LOG2W];
    logic                   vld_d [0:LOG2W];
    kpg_t [WIDTH:0]         kpg_d [0:LOG2W];
    logic [WIDTH-1:0]       hs_d  [0:LOG2W];
    kpg_t [WIDTH:0]         lvl   [0:LOG2W-1];

    logic [WIDTH-1:0] b_eff;
    kpg_t [WIDTH:0]   kpg_in;
    logic             advance;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q, sum_d, carry;
    logic             cout_q, cout_d, ovf_q, zero_q;
    kpg_t             top_k;

    assign b_eff        = bus.sub ? ~bus.b : bus.b;
    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;

    // Vector index 0 is the carry-in (bit position -1).
    always_comb begin
        kpg_in[0] = (bus.sub || bus.cin) ? KPG_GEN : KPG_KILL;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            kpg_in[i+1] = {bus.a[i] & b_eff[i], bus.a[i] | b_eff[i]};
        end
    end

    for (genvar j = 0; j < LOG2W; j++) begin : g_dbl
        for (genvar i = 0; i <= WIDTH; i++) begin : g_pos
            if (i >= (1 << j)) begin : g_cell
                kpg_cell u_cell (
                    .hi_i  (kpg_q[j][i]),
                    .lo_i  (kpg_q[j][i - (1 << j)]),
                    .out_o (lvl[j][i])
                );
            end else begin : g_pass
                assign lvl[j][i] = kpg_q[j][i];
            end
        end
    end

    for (genvar r = 0; r <= LOG2W; r++) begin : g_rank
        if (r == 0) begin : g_in
            assign vld_d[r] = bus.in_valid;
            assign kpg_d[r] = kpg_in;
            assign hs_d[r]  = bus.a ^ b_eff;
        end else begin : g_lvl
            assign vld_d[r] = vld_q[r-1];
            assign kpg_d[r] = lvl[r-1];
            assign hs_d[r]  = hs_q[r-1];
        end
    end

    // LOG2W levels leave the top position one span short of the carry-in,
    // so the carry-out takes one extra combine against index 0.
    kpg_cell u_cout (
        .hi_i  (kpg_q[LOG2W][WIDTH]),
        .lo_i  (kpg_q[LOG2W][0]),
        .out_o (top_k)
    );

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            carry[i] = (kpg_q[LOG2W][i] == KPG_GEN);
        end
    end

    assign sum_d  = hs_q[LOG2W] ^ carry;
    assign cout_d = (top_k == KPG_GEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r <= LOG2W; r++) begin
                vld_q[r] <= 1'b0;
                kpg_q[r] <= '0;
                hs_q[r]  <= '0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            if (advance) begin
                for (int unsigned r = 0; r <= LOG2W; r++) begin
                    vld_q[r] <= vld_d[r];
                    kpg_q[r] <= kpg_d[r];
                    hs_q[r]  <= hs_d[r];
                end
                out_valid_q <= vld_q[LOG2W];
                sum_q       <= sum_d;
                cout_q      <= cout_d;
                ovf_q       <= carry[WIDTH-1] ^ cout_d;
                zero_q      <= (sum_d == '0);
            end
            if (bus.flush) begin
                for (int unsigned r = 0; r <= LOG2W; r++) begin
                    vld_q[r] <= 1'b0;
                end
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: doc/rd_adder_pipe.md
# rd_adder_pipe

Parametrised, pipelined recursive-doubling (kill/propagate/generate) adder/subtractor for the ALU datapath. It is the successor to the fixed 8-bit combinational KPG adder. Width is generic (power of two). One register rank sits after each doubling level, so the block sustains one operation per clock. Operands enter and results leave through valid/ready handshakes; the whole pipe stalls on back-pressure. It feeds the ALU result mux and the flag register.

## Interface
- WIDTH, 8, operand width; power of two, ≥ 2
- LOG2W, $clog2(WIDTH), number of doubling levels (derived; not overridden)
- clk  in  1  single clock; every register samples on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; drops every in-flight operation
- in_valid  in  1  operand set present
- in_ready  out  1  pipe can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A−B (B inverted, carry-in forced 1)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; for sub, 1 = no borrow
- ovf  out  1  two's-complement overflow
- zero  out  1  sum == 0

## Operation
- KPG encoding per bit: kill = 2'b00, generate = 2'b11, propagate = 2'b01 (2'b10 is also treated as propagate).
  - Bit i: kill if a_i = b'_i = 0; generate if both are 1; else propagate. b' = sub ? ~b : b.
- Carry-in is position −1: generate if the effective cin = 1, else kill. It is shifted in as the LSB of the WIDTH+1 KPG vector.
- Doubling level j (0..LOG2W−1): for each position i ≥ 2^j, combine(hi = kpg[i], lo = kpg[i−2^j]).
  - combine returns lo when hi is propagate, else hi.
  - Positions below 2^j pass through unchanged, which is the same pattern as the 8-bit stage-3 mux.
- After LOG2W levels every position is resolved to kill or generate. A residual propagate is a design error; the bench asserts it never occurs.
  - carry_i = (kpg[i−1] == generate)
  - sum_i = a_i ^ b'_i ^ carry_i
  - cout = resolved kpg[WIDTH−1] == generate
  - ovf = carry into MSB ^ cout
- Each stage register carries: valid, the KPG vector, and the propagate half-sum vector a ^ b'. Operands are not otherwise carried.
- advance = !out_valid || out_ready; in_ready = advance.
  - When advance = 1, all stage registers shift one rank.
  - When advance = 0, all stage registers hold.
- Bubbles (valid = 0) shift like data and are not squeezed out.
- flush = 1 clears every valid bit at the next edge, including out_valid, regardless of advance. An operand presented in the same cycle is dropped, even though in_ready is high.
- Reset (async): every valid bit, sum, cout, ovf and zero go to 0 immediately. Data registers also clear to 0.
  - in_ready reads 1 while reset is held.
  - Reset mid-operation discards all in-flight work with no partial output.

## Timing
- LAT = LOG2W + 2 register ranks: input KPG rank, LOG2W doubling ranks, output rank. LAT = 5 for WIDTH = 8, 6 for WIDTH = 16.
- An operand accepted at edge k (in_valid && in_ready) has its result on the outputs with out_valid = 1 right after edge k+LAT−1, provided no stall occurs in between.
- Each stall cycle (out_valid && !out_ready) adds exactly one cycle of latency to every item in flight.
- Throughput is 1 op per clock with out_ready held high.
- Results leave in acceptance order. No item is lost or duplicated across stalls.
- Outputs are registered only; no combinational path from a/b to sum.
- Combinational paths in_ready ← out_valid, out_ready are permitted (single-level ready chain).

## Structure
- Package kpg_pkg holds:
  - constants KPG_KILL, KPG_GEN, KPG_PROP
  - a 2-bit kpg_t typedef
  - function is_prop(kpg_t)
- Sub-module kpg_cell: combinational 2:1 KPG combine (hi, lo → out). It is instantiated per position per level by generate loops.
- The stage register rank is a generate loop inside rd_adder_pipe; there is no separate module.

## Test plan
- WIDTH=8, sub=0, a=8'h7F, b=8'h01, cin=0 → after 5 cycles: sum=8'h80, cout=0, ovf=1, zero=0.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0, zero=1. Then sub=1, a=8'h05, b=8'h07 → sum=8'hFE, cout=0, ovf=0.
- Stream of 16 back-to-back ops with out_ready low for 3 cycles mid-stream:
  - in_ready low exactly those 3 cycles
  - all 16 results in order, none lost or duplicated
  - last result 3 cycles later than the unstalled case
- 4 ops in flight, then flush pulse → out_valid=0 next cycle, none of the 4 emerge; the next accepted op appears after LAT.
- rst asserted asynchronously mid-stream (between edges) → out_valid, sum, cout, ovf, zero are 0 before the next edge. After release, the first op's result appears after 5 cycles.
- WIDTH=16, 10 000 random a/b/cin/sub with random out_ready → every result matches a+b+cin / a−b model, including cout and ovf; no residual propagate asserted.
